// File: rtl/sfx_sequencer.sv
// sfx_sequencer: sweeps a VCO frequency from start_freq to end_freq in
// steps of `step`, one step every max(tick_div,1) clocks. It then holds
// end_freq for hold_ticks+1 ticks and pulses done for one cycle.
//
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   start_valid/ready, start_freq, end_freq, step, tick_div, hold_ticks,
//   mixer_in       - effect request; all fields are sampled on accept
//   abort          - synchronous cancel; the effect ends without done
//   vco_freq, mixer - registered controls for the sound generator
//   busy, done     - status: busy in SWEEP/HOLD, done pulses on completion
module sfx_sequencer #(
    parameter int FREQ_W = 12,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [FREQ_W-1:0] start_freq,
    input  logic [FREQ_W-1:0] end_freq,
    input  logic [7:0]        step,
    input  logic [DIV_W-1:0]  tick_div,
    input  logic [7:0]        hold_ticks,
    input  logic [3:0]        mixer_in,
    input  logic              abort,
    output logic [FREQ_W-1:0] vco_freq,
    output logic [3:0]        mixer,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SWEEP, HOLD, DONE} state_t;

    state_t            state;
    logic [DIV_W-1:0]  tick_cnt;
    logic [7:0]        hold_cnt;
    logic [FREQ_W-1:0] end_q;
    logic [7:0]        step_q;
    logic [DIV_W-1:0]  reload_q;
    logic [7:0]        hold_q;
    logic [3:0]        mix_q;

    logic              accept;
    logic              tick;
    logic [DIV_W-1:0]  div_m1;
    logic [FREQ_W:0]   up_sum;
    logic [FREQ_W-1:0] dn_diff;
    logic [FREQ_W-1:0] step_w;
    logic [FREQ_W-1:0] next_up;
    logic [FREQ_W-1:0] next_dn;

    assign start_ready = (state == IDLE) & ~abort;
    assign accept      = start_valid & start_ready;
    assign busy        = (state == SWEEP) | (state == HOLD);
    assign done        = (state == DONE);
    assign tick        = (tick_cnt == '0);

    // tick_div of 0 behaves like 1 (tick every cycle)
    assign div_m1 = (tick_div == '0) ? '0 : tick_div - 1'b1;

    // Extra carry bit keeps the upward sum from wrapping past the top of
    // the frequency range; the downward path compares the remaining
    // distance against step, so it can never underflow. A zero step
    // jumps straight to the end frequency.
    assign step_w  = FREQ_W'(step_q);
    assign up_sum  = {1'b0, vco_freq} + (FREQ_W+1)'(step_q);
    assign dn_diff = vco_freq - end_q;
    assign next_up = (step_q == '0 || up_sum > {1'b0, end_q}) ? end_q : up_sum[FREQ_W-1:0];
    assign next_dn = (step_q == '0 || dn_diff <= step_w) ? end_q : vco_freq - step_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            vco_freq <= '0;
            mixer    <= '0;
            tick_cnt <= '0;
            hold_cnt <= '0;
            end_q    <= '0;
            step_q   <= '0;
            reload_q <= '0;
            hold_q   <= '0;
            mix_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        end_q    <= end_freq;
                        step_q   <= step;
                        reload_q <= div_m1;
                        hold_q   <= hold_ticks;
                        mix_q    <= mixer_in;
                        vco_freq <= start_freq;
                        tick_cnt <= div_m1;
                        mixer    <= mixer_in;
                        state    <= SWEEP;
                    end
                end
                SWEEP, HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                        mixer <= '0;
                    end else begin
                        tick_cnt <= tick ? reload_q : tick_cnt - 1'b1;
                        if (tick) begin
                            if (state == SWEEP) begin
                                if (vco_freq == end_q) begin
                                    state    <= HOLD;
                                    hold_cnt <= hold_q;
                                end else if (end_q > vco_freq) begin
                                    vco_freq <= next_up;
                                end else begin
                                    vco_freq <= next_dn;
                                end
                            end else if (hold_cnt == '0) begin
                                state <= DONE;
                                mixer <= '0;
                            end else begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // DONE (with or without abort) always returns to IDLE
                    state <= IDLE;
                    mixer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomized bench for sfx_sequencer. For each effect the expected
// per-cycle trace (busy, done, vco_freq) is built from the sweep rules:
// the list of visited frequencies, each held for one tick period, then
// hold_ticks+1 periods at end_freq, then a single done cycle.
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [11:0] start_freq;
    logic [11:0] end_freq;
    logic [7:0]  step;
    logic [15:0] tick_div;
    logic [7:0]  hold_ticks;
    logic [3:0]  mixer_in;
    logic        abort;
    logic [11:0] vco_freq;
    logic [3:0]  mixer;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    sfx_sequencer #(.FREQ_W(12), .DIV_W(16)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_freq(start_freq), .end_freq(end_freq), .step(step),
        .tick_div(tick_div), .hold_ticks(hold_ticks), .mixer_in(mixer_in),
        .abort(abort), .vco_freq(vco_freq), .mixer(mixer),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ab: -1 no abort, -2 random abort point, >=0 abort after that trace cycle
    task automatic run_effect(input int s, input int e, input int st, input int td,
                              input int h, input int mx, input int ab);
        int vals[$];
        int tv[$];
        int tb[$];
        int td1, f, len, ab_at, last;
        bit aborted;
        td1 = (td == 0) ? 1 : td;
        f = s;
        vals.push_back(f);
        while (f != e) begin
            if (st == 0)     f = e;
            else if (e > f)  f = (f + st > e) ? e : f + st;
            else             f = (f - e <= st) ? e : f - st;
            vals.push_back(f);
        end
        foreach (vals[k])
            for (int c = 0; c < td1; c++) begin tv.push_back(vals[k]); tb.push_back(1); end
        for (int c = 0; c < (h + 1) * td1; c++) begin tv.push_back(e); tb.push_back(1); end
        tv.push_back(e); tb.push_back(0);   // done cycle
        len = tv.size();
        ab_at = ab;
        if (ab == -2) ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;

        @(negedge clk);
        chk("ready_idle", start_ready, 1);
        start_freq = 12'(s); end_freq = 12'(e); step = 8'(st);
        tick_div = 16'(td); hold_ticks = 8'(h); mixer_in = 4'(mx);
        start_valid = 1'b1;
        @(posedge clk); #1;
        // scramble the request fields: the running effect must ignore them
        start_freq = 12'($urandom); end_freq = 12'($urandom); step = 8'($urandom);
        tick_div = 16'($urandom); hold_ticks = 8'($urandom); mixer_in = 4'($urandom);
        start_valid = 1'($urandom);
        aborted = 0;
        last = tv[len - 1];
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk("busy", busy, tb[i]);
            chk("done", done, (i == len - 1) ? 1 : 0);
            chk("vco", vco_freq, tv[i]);
            chk("mixer", mixer, tb[i] ? mx : 0);
            chk("ready_busy", start_ready, 0);
            if (i == ab_at) begin abort = 1'b1; aborted = 1; last = tv[i]; end
            @(posedge clk); #1;
            abort = 1'b0;
            start_valid = (!aborted && i + 1 < len) ? 1'($urandom) : 1'b0;
            if (aborted) break;
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_vco", vco_freq, last);
        chk("idle_mixer", mixer, 0);
        chk("idle_ready", start_ready, 1);
    endtask

    initial begin
        int s, e;
        reset = 1'b1; start_valid = 1'b0; abort = 1'b0;
        start_freq = '0; end_freq = '0; step = '0; tick_div = '0;
        hold_ticks = '0; mixer_in = '0;
        #12;
        chk("rst_vco", vco_freq, 0);
        chk("rst_mixer", mixer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_effect(100, 130, 10, 4, 2, 4'b0001, -1);  // up sweep
        run_effect(50, 5, 20, 1, 1, 4'b0110, -1);     // clamped down sweep
        run_effect(200, 200, 7, 0, 0, 4'b1000, -1);   // start==end, tick_div 0
        run_effect(4090, 4095, 255, 2, 0, 4'b1111, -1); // overflow clamp
        run_effect(10, 0, 0, 3, 1, 4'b0011, -1);      // step 0 jumps to end
        run_effect(10, 10, 5, 2, 3, 4'b0101, 4);      // abort in HOLD
        run_effect(0, 3, 1, 1, 0, 4'b1001, 1);        // abort in SWEEP

        // abort together with start_valid in IDLE: no accept
        @(negedge clk);
        abort = 1'b1; start_valid = 1'b1; start_freq = 12'd77;
        #1 chk("ready_abort", start_ready, 0);
        @(posedge clk); #1 abort = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        chk("abort_noacc_busy", busy, 0);

        for (int t = 0; t < 30; t++) begin
            s = $urandom_range(0, 4095);
            e = s + $urandom_range(0, 600) - 300;
            if (e < 0) e = 0;
            if (e > 4095) e = 4095;
            run_effect(s, e, $urandom_range(0, 255), $urandom_range(0, 4),
                       $urandom_range(0, 3), $urandom_range(0, 15), -2);
        end

        // asynchronous reset mid-sweep, between clock edges
        @(negedge clk);
        start_freq = 12'd0; end_freq = 12'd300; step = 8'd1; tick_div = 16'd4;
        hold_ticks = 8'd0; mixer_in = 4'b0010; start_valid = 1'b1;
        @(posedge clk); #1 start_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_vco", vco_freq, 0);
        chk("arst_mixer", mixer, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(posedge clk); #1 reset = 1'b0;
        run_effect(40, 20, 6, 2, 1, 4'b0100, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have parameter FREQ_W, default 12, width of frequency values (matches VCO frequency inputs).
REQ-002 SHALL have parameter DIV_W, default 16, width of tick divider.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_valid  input  1  request to start a sweep effect.
REQ-006 SHALL have port start_ready  output  1  block can accept a request (combinational).
REQ-007 SHALL have port start_freq  input  FREQ_W  initial VCO frequency, sampled on accept.
REQ-008 SHALL have port end_freq  input  FREQ_W  final VCO frequency, sampled on accept.
REQ-009 SHALL have port step  input  8  frequency change per tick, sampled on accept.
REQ-010 SHALL have port tick_div  input  DIV_W  clocks per tick, sampled on accept.
REQ-011 SHALL have port hold_ticks  input  8  ticks to hold end_freq, sampled on accept.
REQ-012 SHALL have port mixer_in  input  4  mix enables {LFO, Noise, VCO2, VCO1}, sampled on accept.
REQ-013 SHALL have port abort  input  1  synchronous cancel of the running effect.
REQ-014 SHALL have port vco_freq  output  FREQ_W  registered frequency for the sound generator.
REQ-015 SHALL have port mixer  output  4  registered mix enables for the sound generator.
REQ-016 SHALL have port busy  output  1  high in SWEEP or HOLD.
REQ-017 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 SHALL implement states IDLE, SWEEP, HOLD, DONE.
REQ-019 start_ready SHALL equal (state==IDLE) & ~abort; accept = start_valid & start_ready.
REQ-020 On accept: latch all sampled inputs; vco_freq <= start_freq; tick counter <= max(tick_div,1)-1; next state SWEEP.
REQ-021 Tick counter SHALL decrement each cycle in SWEEP/HOLD; tick event when counter==0, with reload to max(tick_div,1)-1; ticks occur every max(tick_div,1) cycles.
REQ-022 SWEEP tick with vco_freq==end: go HOLD, hold counter <= latched hold_ticks, vco_freq unchanged.
REQ-023 SWEEP tick, end>vco_freq: vco_freq <= min(vco_freq+step, end), sum in FREQ_W+1 bits, no wrap.
REQ-024 SWEEP tick, end<vco_freq: vco_freq <= max(vco_freq-step, end), no underflow wrap.
REQ-025 step==0 SHALL set vco_freq to end on the first SWEEP tick.
REQ-026 HOLD tick: hold counter==0 -> DONE, else hold counter decrements; hold_ticks=0 leaves on first tick.
REQ-027 DONE SHALL last one cycle with done=1, then IDLE.
REQ-028 mixer SHALL equal latched mixer_in in SWEEP and HOLD, 4'b0000 otherwise (registered, updated with state).
REQ-029 vco_freq SHALL retain its last value in DONE/IDLE and after abort.
REQ-030 abort in SWEEP, HOLD or DONE: next state IDLE, done not asserted, mixer 0 next cycle.
REQ-031 abort and start_valid same cycle in IDLE: no accept, stay IDLE.
REQ-032 Changes to sampled inputs after accept SHALL not affect the running effect.

Reset
REQ-033 On reset assertion, immediately (asynchronously): state IDLE, vco_freq 0, mixer 0, busy 0, done 0, tick and hold counters 0.
REQ-034 Reset mid-effect SHALL discard the effect; start_ready high on first cycle after release (abort low).

Verification
REQ-035 Up sweep: start=100,end=130,step=10,tick_div=4,hold=2,mixer_in=0001 -> vco_freq 100,110,120,130 at 4-cycle intervals, HOLD 3 ticks, done one cycle, mixer 0001 only while busy.
REQ-036 Clamped down sweep: start=50,end=5,step=20,tick_div=1 -> 50,30,10,5 on consecutive cycles, never wraps.
REQ-037 Boundary: start=end=200, hold=0, tick_div=0 -> HOLD after 1 cycle, DONE after 1 more, vco_freq stays 200.
REQ-038 Overflow: start=4090,end=4095,step=255 -> vco_freq 4095 on first tick, no wrap.
REQ-039 Abort during HOLD -> IDLE next cycle, done never pulses, mixer 0, vco_freq holds; start_valid while busy not accepted.
REQ-040 Async reset mid-SWEEP between clock edges -> outputs 0 before next edge; new request accepted first cycle after release.
